lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lock_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - 8-digit keypad lock with timed unlock and failure lockout
// Optional code reprogramming from OPEN is enabled by defining LOCK_CTRL_CODE_PROG_EN.
module lock_ctrl #(
  parameter int unsigned OPEN_CYCLES  = 16,
  parameter int unsigned LOCK_CYCLES  = 64,
  parameter int unsigned MAX_FAILS    = 3,
  parameter logic [31:0] DEFAULT_CODE = 32'h1234_5678
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       unlock,
  output logic       alarm,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt,
  output logic [2:0] mode
);

  localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    LOCKOUT = 3'd3,
    PROG    = 3'd4
  } state_t;

  state_t        state, state_d;
  logic          unlock_d, alarm_d;
  logic [2:0]    digit_d, fail_d;
  logic [TW-1:0] timer, timer_d;
  logic          mismatch, mismatch_d;
  logic [31:0]   code;
  logic [31:0]   code_shift;
  logic [3:0]    exp_nibble;
  logic [3:0]    digit;
  logic          is_digit, is_clear, bad;
  logic [2:0]    fail_inc;

  assign digit      = key_code[3:0];
  assign is_digit   = key_valid && !key_code[4];
  assign is_clear   = key_valid && (key_code == 5'h10);
  assign code_shift = code << {digit_cnt, 2'b00};
  assign exp_nibble = code_shift[31:28];
  assign bad        = mismatch || (digit != exp_nibble);
  assign fail_inc   = fail_cnt + 3'd1;
  assign mode       = state;

`ifdef LOCK_CTRL_CODE_PROG_EN
  logic        is_prog;
  logic [31:0] code_d, shadow, shadow_d;
  assign is_prog = key_valid && (key_code == 5'h11);
`else
  assign code = DEFAULT_CODE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
      digit_cnt <= 3'd0;
      fail_cnt  <= 3'd0;
      timer     <= '0;
      mismatch  <= 1'b0;
`ifdef LOCK_CTRL_CODE_PROG_EN
      code      <= DEFAULT_CODE;
      shadow    <= 32'd0;
`endif
    end else begin
      state     <= state_d;
      unlock    <= unlock_d;
      alarm     <= alarm_d;
      digit_cnt <= digit_d;
      fail_cnt  <= fail_d;
      timer     <= timer_d;
      mismatch  <= mismatch_d;
`ifdef LOCK_CTRL_CODE_PROG_EN
      code      <= code_d;
      shadow    <= shadow_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    unlock_d   = unlock;
    alarm_d    = alarm;
    digit_d    = digit_cnt;
    fail_d     = fail_cnt;
    timer_d    = timer;
    mismatch_d = mismatch;
`ifdef LOCK_CTRL_CODE_PROG_EN
    code_d     = code;
    shadow_d   = shadow;
`endif
    case (state)
      IDLE: begin
        if (is_digit) begin
          state_d    = ENTRY;
          digit_d    = 3'd1;
          mismatch_d = (digit != exp_nibble);
        end
      end
      ENTRY: begin
        if (is_digit) begin
          // Verdict only on the 8th digit so timing/alarms leak nothing about which digit was wrong
          if (digit_cnt == 3'd7) begin
            digit_d    = 3'd0;
            mismatch_d = 1'b0;
            if (!bad) begin
              state_d  = OPEN;
              unlock_d = 1'b1;
              fail_d   = 3'd0;
              timer_d  = OPEN_LOAD;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == 3'(MAX_FAILS)) begin
                state_d = LOCKOUT;
                alarm_d = 1'b1;
                timer_d = LOCK_LOAD;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            digit_d    = digit_cnt + 3'd1;
            mismatch_d = bad;
          end
        end else if (is_clear) begin
          state_d    = IDLE;
          digit_d    = 3'd0;
          mismatch_d = 1'b0;
        end
      end
      OPEN: begin
`ifdef LOCK_CTRL_CODE_PROG_EN
        if (is_prog) begin
          state_d  = PROG;
          unlock_d = 1'b0;
          digit_d  = 3'd0;
          timer_d  = '0;
        end else
`endif
        if (timer == '0) begin
          state_d  = IDLE;
          unlock_d = 1'b0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          state_d = IDLE;
          alarm_d = 1'b0;
          fail_d  = 3'd0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
`ifdef LOCK_CTRL_CODE_PROG_EN
      PROG: begin
        if (is_digit) begin
          shadow_d = {shadow[27:0], digit};
          if (digit_cnt == 3'd7) begin
            code_d  = {shadow[27:0], digit};
            state_d = IDLE;
            digit_d = 3'd0;
          end else begin
            digit_d = digit_cnt + 3'd1;
          end
        end else if (is_clear) begin
          state_d = IDLE;
          digit_d = 3'd0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// tb/tb_lock_ctrl.sv - directed scoreboard bench for lock_ctrl
// Expected output vectors are queued as each key is driven and checked after the clock edge.
module tb_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       unlock, alarm;
  logic [2:0] digit_cnt, fail_cnt, mode;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [2:0] M_IDLE = 3'd0, M_ENTRY = 3'd1, M_OPEN = 3'd2, M_LOCK = 3'd3, M_PROG = 3'd4;
  localparam logic [4:0] K_CLEAR = 5'h10, K_PROG = 5'h11, K_UNK = 5'h15;

  lock_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .unlock(unlock), .alarm(alarm), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input logic [2:0] m, input logic [2:0] d, input logic [2:0] f,
                                     input logic u, input logic a);
    return {u, a, d, f, m};
  endfunction

  task automatic compare_head();
    exp_t e;
    logic [10:0] obs;
    obs = {unlock, alarm, digit_cnt, fail_cnt, mode};
    e = exp_q.pop_front();
    n_cmp++;
    assert (obs === e.v) else begin
      n_bad++;
      $error("FAIL %s: observed u/a/dig/fail/mode=%b/%b/%0d/%0d/%0d expected %b/%b/%0d/%0d/%0d",
             e.tag, obs[10], obs[9], obs[8:6], obs[5:3], obs[2:0],
             e.v[10], e.v[9], e.v[8:6], e.v[5:3], e.v[2:0]);
    end
  endtask

  task automatic step(input logic kv, input logic [4:0] kc, input string tag, input logic [10:0] ev);
    exp_t e;
    e.tag = tag;
    e.v = ev;
    exp_q.push_back(e);
    key_valid = kv;
    key_code = kc;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    compare_head();
  endtask

  task automatic check_now(input string tag, input logic [10:0] ev);
    exp_t e;
    e.tag = tag;
    e.v = ev;
    exp_q.push_back(e);
    compare_head();
  endtask

  task automatic enter8(input logic [31:0] c, input logic [2:0] m_mid, input logic [2:0] f_mid,
                        input logic [10:0] ev_last, input string tag);
    for (int i = 0; i < 7; i++)
      step(1'b1, {1'b0, c[31-4*i -: 4]}, tag, pk(m_mid, 3'(i + 1), f_mid, 1'b0, 1'b0));
    step(1'b1, {1'b0, c[3:0]}, {tag, "_last"}, ev_last);
  endtask

  task automatic ride_open(input string tag);
    for (int i = 1; i < 16; i++) step(1'b0, 5'd0, tag, pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0));
    step(1'b0, 5'd0, {tag, "_end"}, pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));
  endtask

  initial begin
    #2;
    check_now("reset_state", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));
    #10;
    rst = 1'b0;

    // Ignored inputs in IDLE: strobe low and unknown function keys
    step(1'b0, 5'h01, "idle_no_strobe", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));
    step(1'b1, K_UNK, "idle_unknown_key", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));
    step(1'b1, K_CLEAR, "idle_clear", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));

    // Correct code, OPEN exactly 16 cycles, keys ignored while open
    enter8(32'h1234_5678, M_ENTRY, 3'd0, pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0), "good");
    for (int i = 1; i < 14; i++) step(1'b0, 5'd0, "open_hold", pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0));
    step(1'b1, K_CLEAR, "open_clear_ignored", pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0));
    step(1'b1, 5'h09, "open_digit_ignored", pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0));
    step(1'b0, 5'd0, "open_expire", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));

    // First digit wrong: no early verdict, fail counted on the 8th
    enter8(32'h9234_5678, M_ENTRY, 3'd0, pk(M_IDLE, 3'd0, 3'd1, 1'b0, 1'b0), "bad1");

    // Partial entry cleared, unknown key mid-entry ignored, then correct code
    step(1'b1, 5'h01, "clr_d1", pk(M_ENTRY, 3'd1, 3'd1, 1'b0, 1'b0));
    step(1'b1, K_UNK, "entry_unknown_key", pk(M_ENTRY, 3'd1, 3'd1, 1'b0, 1'b0));
    step(1'b1, 5'h02, "clr_d2", pk(M_ENTRY, 3'd2, 3'd1, 1'b0, 1'b0));
    step(1'b1, 5'h03, "clr_d3", pk(M_ENTRY, 3'd3, 3'd1, 1'b0, 1'b0));
    step(1'b1, K_CLEAR, "clear_entry", pk(M_IDLE, 3'd0, 3'd1, 1'b0, 1'b0));
    enter8(32'h1234_5678, M_ENTRY, 3'd1, pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0), "after_clear");
    ride_open("open2");

    // Three failures -> lockout for exactly 64 cycles, keys ignored
    enter8(32'h1234_5679, M_ENTRY, 3'd0, pk(M_IDLE, 3'd0, 3'd1, 1'b0, 1'b0), "lk_f1");
    enter8(32'h0000_0000, M_ENTRY, 3'd1, pk(M_IDLE, 3'd0, 3'd2, 1'b0, 1'b0), "lk_f2");
    enter8(32'h1234_5670, M_ENTRY, 3'd2, pk(M_LOCK, 3'd0, 3'd3, 1'b0, 1'b1), "lk_f3");
    step(1'b1, 5'h01, "lock_digit_ignored", pk(M_LOCK, 3'd0, 3'd3, 1'b0, 1'b1));
    step(1'b1, K_CLEAR, "lock_clear_ignored", pk(M_LOCK, 3'd0, 3'd3, 1'b0, 1'b1));
    step(1'b1, K_PROG, "lock_prog_ignored", pk(M_LOCK, 3'd0, 3'd3, 1'b0, 1'b1));
    for (int i = 4; i < 64; i++) step(1'b0, 5'd0, "lock_hold", pk(M_LOCK, 3'd0, 3'd3, 1'b0, 1'b1));
    step(1'b0, 5'd0, "lock_expire", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));

    // Asynchronous reset mid-entry
    for (int i = 1; i <= 5; i++)
      step(1'b1, 5'(i), "pre_rst", pk(M_ENTRY, 3'(i), 3'd0, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));
    #3;
    rst = 1'b0;
    enter8(32'h1234_5678, M_ENTRY, 3'd0, pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0), "post_rst");

`ifdef LOCK_CTRL_CODE_PROG_EN
    step(1'b1, K_PROG, "enter_prog", pk(M_PROG, 3'd0, 3'd0, 1'b0, 1'b0));
    step(1'b1, K_PROG, "prog_prog_ignored", pk(M_PROG, 3'd0, 3'd0, 1'b0, 1'b0));
    enter8(32'hABCD_0123, M_PROG, 3'd0, pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0), "prog_digits");
    enter8(32'h1234_5678, M_ENTRY, 3'd0, pk(M_IDLE, 3'd0, 3'd1, 1'b0, 1'b0), "old_code");
    enter8(32'hABCD_0123, M_ENTRY, 3'd1, pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0), "new_code");
    ride_open("open_new");
`else
    step(1'b1, K_PROG, "prog_ignored", pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0));
    for (int i = 2; i < 16; i++) step(1'b0, 5'd0, "open3", pk(M_OPEN, 3'd0, 3'd0, 1'b1, 1'b0));
    step(1'b0, 5'd0, "open3_end", pk(M_IDLE, 3'd0, 3'd0, 1'b0, 1'b0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
